// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: instruction-bus request/response, the
// decode-facing output record, the fetch FSM encoding and reset defaults.
package fetch_pkg;

    localparam logic [63:0]  PC_INIT_DEFAULT = 64'h8000_0000;
    localparam int unsigned  PC_STEP_DEFAULT = 4;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [31:0] raw_instr;
    } instr_t;

    typedef struct packed {
        instr_t      instr;
        logic [63:0] pc;
    } fetch_data_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FLUSH
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage boundary: instruction bus, hazard/redirect inputs and the
// instruction handed to decode.
interface fetch_if;
    import fetch_pkg::*;

    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;
    logic        dataF_valid;

    modport master (
        output ireq,
        output dataF,
        output dataF_valid,
        input  iresp,
        input  stall,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  ireq,
        input  dataF,
        input  dataF_valid,
        output iresp,
        output stall,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/fetch_pcselect.sv
// Next-PC mux: redirect target beats sequential advance, otherwise hold.
module fetch_pcselect #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic [63:0] pc_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    input  logic        advance_i,
    output logic [63:0] pc_d_o
);

    always_comb begin
        pc_d_o = pc_i;
        if (redirect_valid_i) begin
            pc_d_o = redirect_pc_i;
        end else if (advance_i) begin
            pc_d_o = pc_i + 64'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one word read at a time and
// holds one instruction for decode. Optional counters under FETCH_PERF_EN.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] PC_INIT = PC_INIT_DEFAULT,
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_bubble
`endif
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    ibus_req_t    req_q, req_d;
    fetch_data_t  data_q, data_d;
    logic         valid_q, valid_d;
    logic         deliver;

    logic         stall, redirect, data_ok;

    assign stall    = bus.stall;
    assign redirect = bus.redirect_valid;
    assign data_ok  = bus.iresp.data_ok;

    fetch_pcselect #(
        .PC_STEP (PC_STEP)
    ) u_pcselect (
        .pc_i             (pc_q),
        .redirect_valid_i (redirect),
        .redirect_pc_i    (bus.redirect_pc),
        .advance_i        (deliver),
        .pc_d_o           (pc_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
            req_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        valid_d = valid_q;
        deliver = 1'b0;

        if (valid_q && !stall) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!redirect && (!valid_q || !stall)) begin
                    req_d.valid = 1'b1;
                    req_d.addr  = pc_q;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // A redirect coinciding with data_ok drops the data and
                // skips FLUSH, since nothing is left in flight.
                if (data_ok) begin
                    req_d.valid = 1'b0;
                    state_d     = IDLE;
                    deliver     = !redirect;
                end else if (redirect) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (data_ok) begin
                    req_d.valid = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (deliver) begin
            data_d.instr.raw_instr = bus.iresp.data[31:0];
            data_d.pc              = pc_q;
            valid_d                = 1'b1;
        end

        if (redirect) begin
            valid_d = 1'b0;
        end
    end

    assign bus.ireq        = req_q;
    assign bus.dataF       = data_q;
    assign bus.dataF_valid = valid_q;

`ifdef FETCH_PERF_EN
    logic [63:0] fetched_q, bubble_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            bubble_q  <= '0;
        end else begin
            if (valid_q && !stall && !redirect) begin
                fetched_q <= fetched_q + 64'd1;
            end
            if (!valid_q && !stall) begin
                bubble_q <= bubble_q + 64'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubble  = bubble_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Randomised bench for fetch: a transaction-level model of the stage plus a
// latency-programmable instruction memory responder.
`timescale 1ns/1ps
module tb_fetch;
    import fetch_pkg::*;

    logic clk;
    logic reset;
    fetch_if bus_if ();

`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetched, perf_bubble;
`endif

    fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubble  (perf_bubble)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    bit          chk_en   = 0;

    // Reference model: outstanding transaction, its fate and the output slot.
    logic [63:0] m_pc;
    bit          m_out, m_disc, m_ov;
    logic [63:0] m_raddr, m_opc;
    logic [63:0] m_fetched, m_bubble;

    int unsigned wcnt, lat, lat_min, lat_max;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h8000_0000;
        m_out = 0; m_disc = 0; m_ov = 0;
        m_raddr = '0; m_opc = '0;
        m_fetched = '0; m_bubble = '0;
        wcnt = 0;
    endtask

    task automatic model_step(input bit s, input bit rv, input logic [63:0] rpc, input bit ok);
        bit cons, delivered;
        cons = m_ov && !s;
        delivered = 0;
        if (m_ov && !s && !rv) m_fetched++;
        if (!m_ov && !s) m_bubble++;
        if (m_out && ok) begin
            if (!m_disc && !rv) begin
                m_ov = 1; m_opc = m_pc; m_pc = m_pc + 64'd4; delivered = 1;
            end
            m_out = 0; m_disc = 0;
        end else if (m_out && rv) begin
            m_disc = 1;
        end else if (!m_out && !rv && (!m_ov || !s)) begin
            m_out = 1; m_raddr = m_pc;
        end
        if (!delivered && cons) m_ov = 0;
        if (rv) begin m_pc = rpc; m_ov = 0; end
    endtask

    // Called at a negedge: drive the inputs for the next posedge and advance the model.
    task automatic step(input bit s, input bit rv, input logic [63:0] rpc);
        bit ok;
        ok = 0;
        if (bus_if.ireq.valid) begin
            wcnt++;
            if (wcnt >= lat) begin
                ok = 1; wcnt = 0;
                lat = $urandom_range(lat_max, lat_min);
            end
        end else begin
            wcnt = 0;
        end
        bus_if.stall          = s;
        bus_if.redirect_valid = rv;
        bus_if.redirect_pc    = rpc;
        bus_if.iresp.addr_ok  = bus_if.ireq.valid;
        bus_if.iresp.data_ok  = ok;
        bus_if.iresp.data     = {$urandom(), mem(bus_if.ireq.addr)};
        model_step(s, rv, rpc, ok);
        @(negedge clk);
    endtask

    task automatic set_lat(input int unsigned lo, input int unsigned hi);
        lat_min = lo; lat_max = hi; lat = hi;
    endtask

    task automatic do_reset();
        bus_if.stall = 0; bus_if.redirect_valid = 0; bus_if.redirect_pc = '0;
        bus_if.iresp = '0;
        reset = 1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic wait_req(input string name);
        int unsigned n;
        n = 0;
        while (!bus_if.ireq.valid && n < 20) begin step(0, 0, '0); n++; end
        if (!bus_if.ireq.valid) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input string name);
        int unsigned n;
        n = 0;
        while (!bus_if.dataF_valid && n < 20) begin step(0, 0, '0); n++; end
        if (!bus_if.dataF_valid) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("ireq_valid", 64'(bus_if.ireq.valid), 64'(m_out));
            if (m_out) chk("ireq_addr", bus_if.ireq.addr, m_raddr);
            chk("dataF_valid", 64'(bus_if.dataF_valid), 64'(m_ov));
            if (m_ov) begin
                chk("dataF_pc", bus_if.dataF.pc, m_opc);
                chk("dataF_instr", 64'(bus_if.dataF.instr.raw_instr), 64'(mem(m_opc)));
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_bubble", perf_bubble, m_bubble);
`endif
        end
    end

    initial begin
        logic [63:0] seen_pc [$];
        logic [63:0] rpc, held;
        int unsigned n, k;
        bit s, rv;

        set_lat(1, 1);
        reset = 1;
        @(negedge clk);
        do_reset();
        chk_en = 1;
        chk("rst_ireq_valid", 64'(bus_if.ireq.valid), 64'd0);
        chk("rst_ireq_addr", bus_if.ireq.addr, 64'd0);
        chk("rst_dataF_valid", 64'(bus_if.dataF_valid), 64'd0);
        chk("rst_dataF", 64'(bus_if.dataF), 64'd0);

        // Sequential fetch with single-cycle memory.
        wait_req("first_req");
        chk("first_addr", bus_if.ireq.addr, 64'h8000_0000);
        n = 0;
        while (seen_pc.size() < 3 && n < 40) begin
            step(0, 0, '0); n++;
            if (bus_if.dataF_valid) seen_pc.push_back(bus_if.dataF.pc);
        end
        chk("seq_count", 64'(seen_pc.size()), 64'd3);
        if (seen_pc.size() == 3) begin
            chk("seq_pc0", seen_pc[0], 64'h8000_0000);
            chk("seq_pc1", seen_pc[1], 64'h8000_0004);
            chk("seq_pc2", seen_pc[2], 64'h8000_0008);
        end

        // Stall with a full output register.
        wait_valid("stall_fill");
        held = m_opc;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, '0);
            chk("stall_no_req", 64'(bus_if.ireq.valid), 64'd0);
            chk("stall_hold_pc", bus_if.dataF.pc, held);
        end
        wait_req("stall_release");
        chk("stall_next_addr", bus_if.ireq.addr, held + 64'd4);

        // Redirect while waiting on a slow response.
        n = 0;
        while (bus_if.ireq.valid && n < 20) begin step(0, 0, '0); n++; end
        set_lat(3, 3);
        wcnt = 0;
        wait_req("redir_req");
        step(0, 1, 64'h8000_0100);
        for (int i = 0; i < 4; i++) begin
            chk("redir_drop", 64'(bus_if.dataF_valid), 64'd0);
            step(0, 0, '0);
        end
        set_lat(1, 1);
        wait_req("redir_next");
        chk("redir_addr", bus_if.ireq.addr, 64'h8000_0100);

        // Redirect in the same cycle as data_ok.
        n = 0;
        while (bus_if.ireq.valid && n < 20) begin step(0, 0, '0); n++; end
        wait_req("same_req");
        step(0, 1, 64'h8000_0200);
        chk("same_idle", 64'(bus_if.ireq.valid), 64'd0);
        chk("same_drop", 64'(bus_if.dataF_valid), 64'd0);
        step(0, 0, '0);
        chk("same_reissue", 64'(bus_if.ireq.valid), 64'd1);
        chk("same_addr", bus_if.ireq.addr, 64'h8000_0200);

        // Asynchronous reset while a request is outstanding.
        set_lat(3, 3);
        n = 0;
        while (bus_if.ireq.valid && n < 20) begin step(0, 0, '0); n++; end
        wcnt = 0;
        wait_req("arst_req");
        reset = 1;
        model_reset();
        #1;
        chk("arst_ireq_valid", 64'(bus_if.ireq.valid), 64'd0);
        chk("arst_ireq_addr", bus_if.ireq.addr, 64'd0);
        chk("arst_dataF_valid", 64'(bus_if.dataF_valid), 64'd0);
        chk("arst_dataF", 64'(bus_if.dataF), 64'd0);
        @(negedge clk);
        do_reset();
        set_lat(1, 3);
        wait_req("arst_first");
        chk("arst_first_addr", bus_if.ireq.addr, 64'h8000_0000);

        // Randomised traffic, including redirects near the top of the address space.
        for (int i = 0; i < 1500; i++) begin
            s  = ($urandom_range(9, 0) < 3);
            rv = ($urandom_range(19, 0) == 0);
            k  = $urandom_range(2, 0);
            if (k == 0)      rpc = 64'h8000_0000 + 64'({$urandom_range(255, 0), 2'b00});
            else if (k == 1) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
            else             rpc = {$urandom(), $urandom()};
            step(s, rv, rpc);
        end

`ifdef FETCH_PERF_EN
        do_reset();
        set_lat(2, 2);
        k = 0; n = 0;
        while (m_fetched < 10 && n < 200) begin
            s = (k < 3) && m_ov && (n % 4 == 1);
            if (s) k++;
            step(s, 0, '0);
            n++;
        end
        chk("perf_stalls", 64'(k), 64'd3);
        chk("perf_fetched_10", perf_fetched, 64'd10);
        chk("perf_bubble_cnt", perf_bubble, m_bubble);
`endif

        step(0, 0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage; first pipeline stage, directly upstream of decode.
- Owns the PC and issues word reads on the instruction bus.
- Holds one fetched instruction in an output register (fetch_data_t) for decode.
- Honours stall from the hazard unit and PC redirects from execute (branch/jump), discarding wrong-path responses still in flight.

Parameters:
- PC_INIT, 64'h8000_0000, PC value loaded at reset.
- PC_STEP, 4, PC increment per sequential fetch (bytes).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- ireq  output  ibus_req_t  instruction bus request (valid, addr)
- iresp  input  ibus_resp_t  instruction bus response (addr_ok, data_ok, data)
- stall  input  1  decode cannot accept dataF this cycle
- redirect_valid  input  1  execute resolved a taken branch/jump
- redirect_pc  input  64  redirect target
- dataF  output  fetch_data_t  instr.raw_instr (32), pc (64)
- dataF_valid  output  1  dataF holds a valid instruction

Behaviour:
- Reset (async, active-high):
  - pc=PC_INIT, state=IDLE
  - ireq.valid=0, ireq.addr=0
  - dataF_valid=0, dataF all-zero
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - FLUSH: request outstanding, response to be discarded.
- IDLE:
  - If the output register is empty, or is being consumed this cycle (dataF_valid & ~stall), and there is no redirect: assert ireq.valid, ireq.addr=pc, go WAIT.
- WAIT:
  - ireq.valid and ireq.addr are held constant until iresp.data_ok.
  - On data_ok: capture raw_instr=iresp.data[31:0] and pc into dataF, set dataF_valid=1, pc<=pc+PC_STEP, go IDLE.
  - Back-to-back issue is allowed next cycle from IDLE, giving 1 instruction per 2 cycles minimum. Throughput beyond that is out of scope.
- FLUSH:
  - Hold ireq until data_ok, drop the data, go IDLE (pc already holds the redirect target).
- Redirect has highest priority in every state:
  - pc<=redirect_pc and dataF_valid<=0, including when stall=1.
  - IDLE stays IDLE.
  - WAIT goes to FLUSH, or straight to IDLE if data_ok occurs in the same cycle; that data is dropped and pc is not incremented.
  - FLUSH stays FLUSH and pc is updated again.
- Output register:
  - Consumed when dataF_valid & ~stall.
  - Cleared the same cycle unless new data_ok arrives.
  - When stall=1 and the register is valid, no new request is issued and dataF is held unchanged.
  - A response arriving while the register is full cannot happen, by the issue rule.
- PC arithmetic: 64-bit, wraps modulo 2^64. No alignment check.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Extra output ports perf_fetched (64) and perf_bubble (64).
  - perf_fetched counts accepted instructions (dataF_valid & ~stall & ~redirect_valid).
  - perf_bubble counts cycles with dataF_valid=0 and no stall.
  - Both reset to 0 and wrap.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- pipes package:
  - fetch_data_t
  - fetch_state_t enum {IDLE, WAIT, FLUSH}
  - PC_INIT default constant
- common package: ibus_req_t, ibus_resp_t.
- One natural sub-module, pcselect: combinational next-PC mux (redirect_pc / pc+PC_STEP / pc). The state machine and output register stay in fetch.

Test Plan:
- Reset then bus answers data_ok after 1 cycle, stall=0:
  - first ireq.addr=8000_0000
  - dataF.pc sequence 8000_0000, 8000_0004, 8000_0008
  - raw_instr matches the memory model
- stall=1 for 5 cycles while dataF_valid=1:
  - dataF unchanged
  - ireq.valid=0 throughout
  - after release, next addr = held pc+4
- Redirect to 8000_0100 while in WAIT, data_ok 3 cycles later:
  - that response is dropped (dataF_valid stays 0)
  - next ireq.addr=8000_0100
- Redirect in the same cycle as data_ok:
  - data dropped
  - pc=redirect target
  - no FLUSH state entered
- Assert reset mid-WAIT:
  - outputs return to reset values immediately (async)
  - first post-reset addr=8000_0000
- With FETCH_PERF_EN, 10 instructions, 3 stall cycles, memory latency 2:
  - perf_fetched=10
  - perf_bubble matches the counted empty, non-stall cycles
